muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU unit owning HI/LO; shift-add multiply and restoring divide on one ALU.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are 0.
module muldiv_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LastCnt = 5'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_op;
  logic [4:0]  r_cnt;
  logic [32:0] r_acc;   // multiply accumulator / divide remainder
  logic [31:0] r_q;     // multiplier / quotient shift register
  logic [31:0] r_b;     // multiplicand / divisor
  logic [31:0] r_hi, r_lo;

  logic [2:0]  w_alu_ctrl;
  logic [31:0] w_alu_a, w_alu_b, w_alu_y;
  logic        w_cout;
  logic [32:0] w_rp, w_sum33, w_acc_nxt;
  logic [31:0] w_q_nxt;
  logic        w_ge, w_early, w_last;
  logic [63:0] w_res;

  // Single ALU instance: add for multiply, sub for divide.
  always_comb begin
    w_alu_ctrl = r_op ? 3'b110 : 3'b010;
    w_alu_a    = r_op ? w_rp[31:0] : r_acc[31:0];
    w_alu_b    = r_b;
    unique case (w_alu_ctrl)
      3'b000:  w_alu_y = w_alu_a & w_alu_b;
      3'b001:  w_alu_y = w_alu_a | w_alu_b;
      3'b010:  w_alu_y = w_alu_a + w_alu_b;
      3'b110:  w_alu_y = w_alu_a - w_alu_b;
      3'b111:  w_alu_y = {31'd0, w_alu_a < w_alu_b};
      default: w_alu_y = 32'd0;
    endcase
  end

  // Carry of the 32-bit add rebuilt from the operand and sum MSBs.
  assign w_cout = (w_alu_a[31] & w_alu_b[31]) | ((w_alu_a[31] | w_alu_b[31]) & ~w_alu_y[31]);

  always_comb begin
    w_rp    = {r_acc[31:0], r_q[31]};
    w_ge    = w_rp >= {1'b0, r_b};
    w_sum33 = r_q[0] ? {w_cout, w_alu_y} : r_acc;
    if (r_op) begin
      w_acc_nxt = w_ge ? {1'b0, w_alu_y} : w_rp;
      w_q_nxt   = {r_q[30:0], w_ge};
    end else begin
      w_acc_nxt = {1'b0, w_sum33[32:1]};
      w_q_nxt   = {w_sum33[0], r_q[31:1]};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] w_mask;
  logic [4:0]  w_shamt;
  // Low (31 - cnt) bits of r_q >> 1 are the multiplier bits not yet consumed.
  always_comb begin
    w_mask  = 32'hFFFF_FFFF >> (6'(r_cnt) + 6'd1);
    w_early = ~r_op && (((r_q >> 1) & w_mask) == 32'd0);
    w_shamt = w_early ? (LastCnt - r_cnt) : 5'd0;
    w_res   = {w_acc_nxt[31:0], w_q_nxt} >> w_shamt;
  end
`else
  assign w_early = 1'b0;
  assign w_res   = {w_acc_nxt[31:0], w_q_nxt};
`endif

  assign w_last = (r_cnt == LastCnt) || w_early;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= 1'b0;
      r_cnt <= 5'd0;
      r_acc <= 33'd0;
      r_q   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op  <= op;
            r_cnt <= 5'd0;
            r_acc <= 33'd0;
            r_q   <= op ? src_a : src_b;
            r_b   <= op ? src_b : src_a;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        StRun: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_hi <= w_res[63:32];
            r_lo <= w_res[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, monitor checks on done.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, op, hi_we, lo_we;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_cyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_sequencer #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    if (!o) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  function automatic int exp_lat(input logic o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!o) begin
      int l;
      l = 1;
      for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
      return l;
    end
`endif
    return 32;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 with no pending op at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] m;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    m = model(o, a, b);
    e.hi = m[63:32];
    e.lo = m[31:0];
    e.start_cyc = cyc + 1;
    e.lat = exp_lat(o, b);
    sb.push_back(e);
  endtask

  // hold=1 keeps start asserted with junk operands through RUN to prove it is ignored.
  task automatic wait_done(input bit hold);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (hold) begin
        src_a = $urandom; src_b = $urandom; op = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 100 cycles, busy=%0b", busy);
      sb.delete();
    end else begin
      @(negedge clk);
      check("idle_after_done", {62'd0, busy, done}, 64'd0);
    end
  endtask

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    issue(o, a, b);
    wait_done(hold);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h1234_5678;
    check("mthi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, 64'hDEAD_BEEF_1234_5678);

    // start wins over a coincident MTHI; writes during RUN are dropped
    issue(1'b0, 32'd3, 32'd5);
    hi_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b1;
    check("start_beats_mthi", {31'd0, busy, hi}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("write_in_run", {hi, lo}, 64'hDEAD_BEEF_1234_5678);
    wait_done(1'b0);

    run_op(1'b0, 32'd3, 32'd5, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'h0000_1234, 32'd0, 1'b0);

    // asynchronous reset mid-operation
    issue(1'b0, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_reset", {30'd0, busy, done, hi, lo}, 96'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'd6, 32'd7, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic        o;
      logic [31:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(0, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(o, a, b, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
